// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op encodings, widths, sequencer state encoding and command record.
package alu_pkg;
  localparam int OPW  = 4;
  localparam int RESW = 8;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;
  typedef struct packed {
    op_e            op;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } cmd_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: command, response and ALU-pin bundle of the sequencer.
//   cmd_*  : valid/ready command channel {op,a,b}
//   rsp_*  : valid/ready result channel {data,err}
//   alu_*  : operand/ctrl/en drive to the ALU and its out/valid return
//   slave  : the sequencer side; master: decode logic, response sink and ALU
interface alu_seq_if;
  import alu_pkg::*;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [OPW-1:0]  cmd_a;
  logic [OPW-1:0]  cmd_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [RESW-1:0] rsp_data;
  logic            rsp_err;
  logic [OPW-1:0]  alu_a;
  logic [OPW-1:0]  alu_b;
  logic [1:0]      alu_ctrl;
  logic            alu_en;
  logic [RESW-1:0] alu_out;
  logic            alu_valid;
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_out, alu_valid,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, alu_a, alu_b, alu_ctrl, alu_en
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_out, alu_valid,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, alu_a, alu_b, alu_ctrl, alu_en
  );
endinterface

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: DEPTH-entry synchronous command FIFO with wrap-bit pointers.
//   push_i/wdata_i : write one entry (never while full)
//   pop_i/rdata_o  : rdata_o shows the head; pop_i advances past it
//   full_o/empty_o : occupancy flags
module alu_seq_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  cmd_t wdata_i,
  input  logic pop_i,
  output cmd_t rdata_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);
  cmd_t          mem_q [DEPTH];
  logic [AW:0]   wr_q;
  logic [AW:0]   rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i) rd_q <= rd_q + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: queues ALU commands, issues them one at a time for LAT cycles and returns results.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : alu_seq_if.slave (command in, response out, ALU pins)
//   ALU_SEQ_DIVZ_EN : when defined, DIV by zero is answered locally with FF/err
module alu_seq
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            live_q;
  logic            divz_q;
  logic            rsp_valid_q;
  logic [RESW-1:0] rsp_data_q;
  logic            rsp_err_q;
  logic [OPW-1:0]  alu_a_q;
  logic [OPW-1:0]  alu_b_q;
  logic [1:0]      alu_ctrl_q;
  logic            alu_en_q;
  cmd_t            head;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            done;
  logic            divz;
  // live_q holds cmd_ready low until the first clock after reset release
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign done = state_q == RESP && bus.rsp_ready;
  assign pop  = !empty && (state_q == IDLE || done);
`ifdef ALU_SEQ_DIVZ_EN
  assign divz = head.op == OP_DIV && head.b == '0;
`else
  assign divz = 1'b0;
`endif
  alu_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (cmd_t'({bus.cmd_op, bus.cmd_a, bus.cmd_b})),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      live_q      <= 1'b0;
      divz_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      alu_en_q    <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        IDLE, RESP:
          if (pop) begin
            // divide-by-zero skips the ALU and goes straight to CAPTURE
            state_q     <= divz ? CAPTURE : ISSUE;
            divz_q      <= divz;
            alu_en_q    <= !divz;
            rsp_valid_q <= 1'b0;
            cnt_q       <= CW'(LAT - 1);
            if (!divz) {alu_ctrl_q, alu_a_q, alu_b_q} <= head;
          end else if (done) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        ISSUE:
          if (cnt_q == '0) begin
            state_q  <= CAPTURE;
            alu_en_q <= 1'b0;
          end else cnt_q <= cnt_q - CW'(1);
        CAPTURE: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= divz_q ? '1 : bus.alu_out;
          rsp_err_q   <= divz_q || !bus.alu_valid;
        end
      endcase
    end
  assign bus.cmd_ready = live_q && !full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.alu_en    = alu_en_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq with a 2-cycle ALU stand-in.
module tb_alu_seq;
  logic clk;
  logic rst;
  logic stuck;
  int   n_tests;
  int   n_fail;
  alu_seq_if bus ();
  alu_seq #(.DEPTH(4), .LAT(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] s1, s2;
  logic       v1, v2;
  function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] ea, eb;
    ea = {4'h0, a};
    eb = {4'h0, b};
    case (op)
      2'd0: return ea + eb;
      2'd1: return ea - eb;
      2'd2: return ea * eb;
      default: return (eb == 8'h00) ? 8'h00 : ea / eb;
    endcase
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 0; s2 <= 0; v1 <= 0; v2 <= 0;
    end else begin
      s1 <= alu_f(bus.alu_ctrl, bus.alu_a, bus.alu_b);
      v1 <= bus.alu_en;
      s2 <= s1;
      v2 <= v1;
    end
  assign bus.alu_out   = s2;
  assign bus.alu_valid = v2 && !stuck;
  logic [1:0] q_op [8];
  logic [3:0] q_a [8];
  logic [3:0] q_b [8];
  int         q_n;
  logic [7:0] r_data [8];
  logic       r_err [8];
  int         r_cyc [8];
  int         r_n, en_cnt, drop_at, chg;
  logic       held;
  logic [7:0] hold;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_cmd(input int i, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    q_op[i] = op; q_a[i] = a; q_b[i] = b;
  endtask
  // Offers q_n commands in order, holds rsp_ready low until cycle ready_at, records
  // responses with the cycle they were taken (cycle 0 = first cycle of the run).
  task automatic run(input int cycles, input int ready_at);
    int   k;
    logic rdy;
    k = 0; r_n = 0; en_cnt = 0; drop_at = -1; chg = 0; held = 0; hold = 0;
    for (int c = 0; c < cycles; c++) begin
      bus.cmd_valid = k < q_n;
      bus.cmd_op = q_op[k & 7];
      bus.cmd_a = q_a[k & 7];
      bus.cmd_b = q_b[k & 7];
      bus.rsp_ready = c >= ready_at;
      rdy = bus.cmd_ready;
      if (!rdy && k < q_n && drop_at < 0) drop_at = k;
      if (bus.alu_en) en_cnt++;
      if (bus.rsp_valid && !bus.rsp_ready) begin
        if (!held) begin held = 1; hold = bus.rsp_data; end
        else if (bus.rsp_data !== hold) chg++;
      end
      if (bus.rsp_valid && bus.rsp_ready && r_n < 8) begin
        r_data[r_n] = bus.rsp_data; r_err[r_n] = bus.rsp_err; r_cyc[r_n] = c; r_n++;
      end
      tick();
      if (rdy && k < q_n) k++;
    end
    bus.cmd_valid = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    tick(); tick();
    n_tests++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b exp 0", bus.cmd_ready); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b exp 0", bus.rsp_valid); end
    n_tests++; if ({bus.rsp_data, bus.rsp_err} !== 9'h0) begin n_fail++; $display("FAIL reset_rsp: got %h/%b exp 00/0", bus.rsp_data, bus.rsp_err); end
    n_tests++; if ({bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.alu_en} !== 11'h0) begin n_fail++; $display("FAIL reset_alu_pins: got %h %h %h %b exp 0", bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.alu_en); end
    rst = 0;
    tick();
    n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL release_cmd_ready: got %b exp 1", bus.cmd_ready); end
  endtask
  task automatic test_add();
    q_n = 1; set_cmd(0, 2'd0, 4'd7, 4'd9);
    run(10, 0);
    n_tests++; if (r_n !== 1) begin n_fail++; $display("FAIL add_count: got %0d exp 1", r_n); end
    n_tests++; if (r_cyc[0] !== 5) begin n_fail++; $display("FAIL add_latency: got %0d exp 5", r_cyc[0]); end
    n_tests++; if (r_data[0] !== 8'h10 || r_err[0] !== 1'b0) begin n_fail++; $display("FAIL add_result: got %h/%b exp 10/0", r_data[0], r_err[0]); end
    n_tests++; if (en_cnt !== 2) begin n_fail++; $display("FAIL add_en_cycles: got %0d exp 2", en_cnt); end
    n_tests++; if (bus.alu_a !== 4'd7 || bus.alu_b !== 4'd9 || bus.alu_ctrl !== 2'd0) begin n_fail++; $display("FAIL add_operand_retain: got %h %h %h exp 7 9 0", bus.alu_a, bus.alu_b, bus.alu_ctrl); end
  endtask
  task automatic test_back_to_back();
    logic [7:0] exp_d [3];
    exp_d = '{8'hFE, 8'hE1, 8'h03};
    q_n = 3; set_cmd(0, 2'd1, 4'd3, 4'd5); set_cmd(1, 2'd2, 4'd15, 4'd15); set_cmd(2, 2'd3, 4'd13, 4'd4);
    run(18, 0);
    n_tests++; if (r_n !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d exp 3", r_n); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (r_data[i] !== exp_d[i] || r_err[i] !== 1'b0) begin n_fail++; $display("FAIL b2b_result%0d: got %h/%b exp %h/0", i, r_data[i], r_err[i], exp_d[i]); end
      n_tests++; if (r_cyc[i] !== 5 + 4 * i) begin n_fail++; $display("FAIL b2b_cycle%0d: got %0d exp %0d", i, r_cyc[i], 5 + 4 * i); end
    end
  endtask
  task automatic test_backpressure();
    logic [7:0] exp_d [6];
    exp_d = '{8'h03, 8'hFF, 8'h0C, 8'h07, 8'h1E, 8'h00};
    q_n = 6;
    set_cmd(0, 2'd0, 4'd1, 4'd2); set_cmd(1, 2'd1, 4'd0, 4'd1); set_cmd(2, 2'd2, 4'd3, 4'd4);
    set_cmd(3, 2'd3, 4'd15, 4'd2); set_cmd(4, 2'd0, 4'd15, 4'd15); set_cmd(5, 2'd1, 4'd9, 4'd9);
    run(50, 20);
    n_tests++; if (drop_at !== 5) begin n_fail++; $display("FAIL bp_ready_drop: accepted %0d before stall exp 5", drop_at); end
    n_tests++; if (!held || hold !== 8'h03 || chg !== 0) begin n_fail++; $display("FAIL bp_hold: got %h changes %0d exp 03 changes 0", hold, chg); end
    n_tests++; if (r_n !== 6) begin n_fail++; $display("FAIL bp_count: got %0d exp 6", r_n); end
    n_tests++; if (r_cyc[0] !== 20) begin n_fail++; $display("FAIL bp_first_cycle: got %0d exp 20", r_cyc[0]); end
    for (int i = 0; i < 6; i++) begin
      n_tests++; if (r_data[i] !== exp_d[i] || r_err[i] !== 1'b0) begin n_fail++; $display("FAIL bp_result%0d: got %h/%b exp %h/0", i, r_data[i], r_err[i], exp_d[i]); end
    end
  endtask
  task automatic test_err_stuck();
    stuck = 1;
    q_n = 2; set_cmd(0, 2'd0, 4'd2, 4'd2); set_cmd(1, 2'd2, 4'd3, 4'd3);
    run(14, 0);
    stuck = 0;
    n_tests++; if (r_n !== 2) begin n_fail++; $display("FAIL err_count: got %0d exp 2", r_n); end
    n_tests++; if (r_err[0] !== 1'b1 || r_err[1] !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b %b exp 1 1", r_err[0], r_err[1]); end
  endtask
  task automatic test_reset_mid();
    q_n = 5;
    set_cmd(0, 2'd0, 4'd1, 4'd1); set_cmd(1, 2'd1, 4'd2, 4'd1); set_cmd(2, 2'd2, 4'd3, 4'd3);
    set_cmd(3, 2'd0, 4'd5, 4'd5); set_cmd(4, 2'd1, 4'd6, 4'd1);
    run(6, 5);
    n_tests++; if (bus.alu_en !== 1'b1 || bus.alu_a !== 4'd2 || bus.alu_ctrl !== 2'd1) begin n_fail++; $display("FAIL rstmid_issue: got en %b a %h ctrl %h exp 1 2 1", bus.alu_en, bus.alu_a, bus.alu_ctrl); end
    rst = 1;
    #1;
    n_tests++; if (bus.alu_en !== 1'b0 || bus.alu_a !== 4'd0 || bus.alu_ctrl !== 2'd0) begin n_fail++; $display("FAIL rstmid_alu: got en %b a %h ctrl %h exp 0 0 0", bus.alu_en, bus.alu_a, bus.alu_ctrl); end
    n_tests++; if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rsp: got rdy %b vld %b data %h exp 0 0 00", bus.cmd_ready, bus.rsp_valid, bus.rsp_data); end
    tick(); tick();
    rst = 0;
    q_n = 0;
    run(15, 0);
    n_tests++; if (r_n !== 0 || en_cnt !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d responses %0d en cycles exp 0 0", r_n, en_cnt); end
    q_n = 1; set_cmd(0, 2'd0, 4'd4, 4'd5);
    run(10, 0);
    n_tests++; if (r_n !== 1 || r_data[0] !== 8'h09 || r_cyc[0] !== 5) begin n_fail++; $display("FAIL rstmid_fresh: got n %0d data %h cyc %0d exp 1 09 5", r_n, r_data[0], r_cyc[0]); end
  endtask
  task automatic test_divz();
    q_n = 1; set_cmd(0, 2'd3, 4'd9, 4'd0);
    run(10, 0);
    n_tests++; if (r_n !== 1) begin n_fail++; $display("FAIL divz_count: got %0d exp 1", r_n); end
`ifdef ALU_SEQ_DIVZ_EN
    n_tests++; if (en_cnt !== 0) begin n_fail++; $display("FAIL divz_en: got %0d exp 0", en_cnt); end
    n_tests++; if (r_data[0] !== 8'hFF || r_err[0] !== 1'b1) begin n_fail++; $display("FAIL divz_result: got %h/%b exp ff/1", r_data[0], r_err[0]); end
    n_tests++; if (r_cyc[0] !== 3) begin n_fail++; $display("FAIL divz_cycle: got %0d exp 3", r_cyc[0]); end
`else
    n_tests++; if (en_cnt !== 2) begin n_fail++; $display("FAIL divz_en: got %0d exp 2", en_cnt); end
    n_tests++; if (r_data[0] !== 8'h00 || r_err[0] !== 1'b0) begin n_fail++; $display("FAIL divz_result: got %h/%b exp 00/0", r_data[0], r_err[0]); end
    n_tests++; if (r_cyc[0] !== 5) begin n_fail++; $display("FAIL divz_cycle: got %0d exp 5", r_cyc[0]); end
`endif
  endtask
  initial begin
    clk = 0; rst = 1; stuck = 0; n_tests = 0; n_fail = 0;
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_a = 0; bus.cmd_b = 0; bus.rsp_ready = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_err_stuck();
    test_reset_mid();
    test_divz();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
